// File: rtl/uart_pkg.sv
// Shared arbiter types and the round-robin search used by the RX arbiter.
package uart_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam int RR_MAX_CH = 8;

    // Returns {found, index}: first set bit of req searching upward from last+1, wrapping at num_ch.
    // Descending loop so the closest candidate is the final assignment.
    function automatic logic [3:0] rr_search(input logic [RR_MAX_CH-1:0] req,
                                             input logic [2:0]           last,
                                             input int                   num_ch);
        logic [3:0] res;
        int         idx;
        res = '0;
        idx = 0;
        for (int k = RR_MAX_CH; k >= 1; k--) begin
            if (k <= num_ch) begin
                idx = (int'(last) + k) % num_ch;
                if (req[idx[2:0]]) begin
                    res = {1'b1, idx[2:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rx_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot grant plus index, searching upward from last_gnt+1.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_mask,
    input  logic [CH_W-1:0]   last_gnt,
    output logic [NUM_CH-1:0] gnt_oh,
    output logic [CH_W-1:0]   gnt_idx
);

    logic [RR_MAX_CH-1:0] req_ext;
    logic [3:0]           res;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_CH-1:0]    = req_mask;
        res                    = rr_search(req_ext, 3'(last_gnt), NUM_CH);
        gnt_idx                = CH_W'(res[2:0]);
        gnt_oh                 = res[3] ? (NUM_CH'(1) << res[2:0]) : '0;
    end

endmodule

// File: rtl/rx_arbiter.sv
// Round-robin arbiter merging NUM_CH RX byte streams into one consumer, bursts of up to MAX_BURST.
// state | meaning:  ST_IDLE | no grant, choosing next channel   ST_GRANT | gnt owns the consumer path
module rx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic [NUM_CH-1:0]            req_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
    output logic [NUM_CH-1:0]            req_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic                         busy
);

    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t        state, state_nxt;
    logic [CH_W-1:0]   gnt, gnt_nxt;
    logic [CH_W-1:0]   last_gnt, last_gnt_nxt;
    logic [BW-1:0]     burst_cnt, burst_cnt_nxt;
    logic [NUM_CH-1:0] pick_oh;
    logic [CH_W-1:0]   pick_idx;
    logic              xfer;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_pick (
        .req_mask (req_valid & ch_en),
        .last_gnt (last_gnt),
        .gnt_oh   (pick_oh),
        .gnt_idx  (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            burst_cnt <= '0;
            last_gnt  <= CH_W'(NUM_CH - 1);
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            burst_cnt <= burst_cnt_nxt;
            last_gnt  <= last_gnt_nxt;
        end
    end

    // Grant decision is taken from registered state only; data path in GRANT is purely combinational.
    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        last_gnt_nxt  = last_gnt;
        burst_cnt_nxt = burst_cnt;
        out_valid     = 1'b0;
        out_data      = '0;
        out_ch        = '0;
        out_last      = 1'b0;
        busy          = 1'b0;
        req_ready     = '0;
        xfer          = 1'b0;

        case (state)
            ST_IDLE: begin
                if (|pick_oh) begin
                    gnt_nxt       = pick_idx;
                    burst_cnt_nxt = '0;
                    state_nxt     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                busy           = 1'b1;
                out_valid      = req_valid[gnt];
                out_data       = req_data[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
                out_ch         = gnt;
                req_ready[gnt] = out_ready;
                out_last       = out_valid && (burst_cnt == BW'(MAX_BURST - 1));
                xfer           = out_valid && out_ready;
                // ch_en is not consulted here so an enable drop never cuts an accepted burst short.
                if (!req_valid[gnt] || (xfer && out_last)) begin
                    state_nxt    = ST_IDLE;
                    last_gnt_nxt = gnt;
                end else if (xfer) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/rx_arbiter.md
RX_ARBITER -- requirements
Module: rx_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4: number of RX byte-stream requesters sharing one consumer; range 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: byte width of each requester stream.
REQ-003 Parameter MAX_BURST, default 4: maximum transfers per grant; range 1..255.
REQ-004 Parameter CH_W, default $clog2(NUM_CH): width of the channel index.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 ch_en  input  NUM_CH  per-channel enable mask; a disabled channel is never granted.
REQ-008 req_valid  input  NUM_CH  per-channel data-valid from each RX read stage.
REQ-009 req_data  input  NUM_CH*DATA_WIDTH  per-channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 req_ready  output  NUM_CH  per-channel ready back to each RX read stage.
REQ-011 out_valid  output  1  arbitrated data valid to the consumer.
REQ-012 out_data  output  DATA_WIDTH  arbitrated data.
REQ-013 out_ch  output  CH_W  index of the channel driving out_data.
REQ-014 out_last  output  1  marks the final transfer of a grant.
REQ-015 out_ready  input  1  consumer ready.
REQ-016 busy  output  1  high while a grant is held.

Function
REQ-017 A transfer occurs on any rising clk edge with out_valid and out_ready both high.
REQ-018 The FSM SHALL have two states: IDLE and GRANT.
REQ-019 IDLE: if any (req_valid & ch_en) bit is set, the FSM selects the first such channel searching upward from last_gnt+1 with modulo-NUM_CH wrap, stores it in gnt, clears burst_cnt, and moves to GRANT on the next edge.
REQ-020 IDLE: out_valid, out_last, busy, and all req_ready bits are 0.
REQ-021 GRANT: out_valid = req_valid[gnt], out_data = req_data[gnt], out_ch = gnt, and req_ready[gnt] = out_ready; all other req_ready bits are 0; this path is combinational with zero added latency.
REQ-022 GRANT: burst_cnt increments by 1 per transfer; its width is ceil(log2(MAX_BURST+1)) bits.
REQ-023 out_last = out_valid AND (burst_cnt == MAX_BURST-1).
REQ-024 GRANT is released to IDLE, with last_gnt set to gnt, on (a) a transfer with out_last high, or (b) any cycle in which req_valid[gnt] is low.
REQ-025 ch_en[gnt] deasserting during GRANT does not abort an accepted transfer; the grant ends at the next boundary defined in REQ-024.
REQ-026 Arbitration overhead is exactly 1 idle cycle between grants; no combinational path exists from req_valid to a grant decision in the same cycle.
REQ-027 Fairness: with all channels continuously valid and enabled, grants rotate 0,1,...,NUM_CH-1,0,...; each grant carries exactly MAX_BURST transfers.
REQ-028 out_valid, once high in GRANT, does not drop before a transfer unless req_valid[gnt] drops.
REQ-029 out_ch and out_data hold their values while out_valid is high and out_ready is low.

Reset
REQ-030 When rst is asserted, the block immediately enters IDLE with gnt = 0, burst_cnt = 0, and last_gnt = NUM_CH-1, so channel 0 wins first.
REQ-031 Outputs during and after reset are out_valid = 0, out_last = 0, busy = 0, req_ready = 0, out_ch = 0, and out_data = 0.
REQ-032 A reset asserted mid-grant abandons the burst; no partial state survives.

Structure
REQ-033 The FSM state encoding (IDLE, GRANT) and the round-robin helper function belong in the shared uart_pkg.
REQ-034 One sub-module, rr_pick, is natural: a combinational round-robin selector taking the request mask and last_gnt and producing a one-hot grant plus an index.

Verification
REQ-035 Single channel: ch2 presents 3 bytes 0x11/0x22/0x33, out_ready=1 -> 1 idle cycle, then 3 transfers with out_ch=2 and no out_last (MAX_BURST=4); release on valid drop.
REQ-036 All 4 channels continuously valid -> grant order 0,1,2,3,0; 4 transfers each; out_last on every 4th transfer; 1-cycle gap between grants.
REQ-037 Backpressure: out_ready low for 5 cycles mid-burst -> out_data/out_ch held stable; burst_cnt unchanged; no req_ready to any channel.
REQ-038 ch_en=4'b1010 with all channels valid -> only channels 1 and 3 are granted, alternating.
REQ-039 rst pulse during transfer 2 of a ch1 burst -> all outputs 0 immediately; first post-reset grant goes to the lowest valid channel searching from 0.
REQ-040 Wrap-around: last_gnt=3, only ch0 and ch3 valid -> ch0 is granted next.
